fab_clk_reset_sequencer: RTL and testbench
==========================================

// Module: fab_clk_reset_sequencer
// PURPOSE
//  Controller for the MSS_CCC fabric clock: watches CCC lock, holds servo/turret logic in reset until
//  FAB_CLK is stable, then releases resets in staged order and distributes prescaled timebase ticks.
//  Sits between the MSS_CCC wrapper (FAB_CLK, FAB_LOCK) and the servo PWM / turret control blocks.
//  Sequences clock-loss recovery so downstream logic never runs on an unlocked clock.
// PARAMETERS
//  LOCK_STABLE_CYCLES  1024  consecutive lock_ok cycles required before reset release (>=2)
//  NUM_STAGES          3     number of staged reset outputs (1..8)
//  STAGE_GAP_CYCLES    16    cycles between successive stage releases, and last stage to READY (>=1)
//  TICK_US_DIV         100   FAB_CLK cycles per TICK_US pulse (100 MHz RCOSC bypass -> 1 us)
//  TICK_MS_DIV         1000  TICK_US pulses per TICK_MS pulse
// PORTS
//  FAB_CLK       in   1           fabric clock from MSS_CCC GLA; sole clock
//  FAB_RESET     in   1           synchronous, active-high reset
//  LOCK_IN       in   1           CCC lock (asynchronous to FAB_CLK); 2-flop synchronised internally
//  LOCK_BYPASS   in   1           static strap: 1 = treat clock as locked (CCC in bypass, lock tied low)
//  CLR_LOCK_LOST in   1           1-cycle pulse clears LOCK_LOST
//  RST_OUT       out  NUM_STAGES  active-high stage resets; bit 0 released first
//  READY         out  1           all stages released, clock locked
//  LOCK_LOST     out  1           sticky: lock dropped after any stage was released
//  TICK_US       out  1           1-cycle pulse every TICK_US_DIV cycles while READY
//  TICK_MS       out  1           1-cycle pulse coincident with every TICK_MS_DIV-th TICK_US
// BEHAVIOUR
//  Reset (FAB_RESET=1 at an edge): state=WAIT_LOCK, RST_OUT=all 1, READY=0, LOCK_LOST=0, TICK_US=0,
//   TICK_MS=0, sync flops=0, all counters=0. Applies from any state, including mid-RELEASE/RUN.
//  lock_ok = lock_sync2 | LOCK_BYPASS (LOCK_IN adds 2 edges of latency; LOCK_BYPASS adds none).
//  FSM, all transitions registered:
//   WAIT_LOCK: lock_ok -> STABLE, cnt=0.
//   STABLE:    cnt++ each edge; !lock_ok -> WAIT_LOCK (LOCK_LOST unchanged, nothing yet released);
//              entered edge + LOCK_STABLE_CYCLES edges with lock_ok held -> RELEASE, RST_OUT[0]<=0.
//   RELEASE:   RST_OUT[k] falls k*STAGE_GAP_CYCLES edges after RELEASE entry; READY rises and
//              state -> RUN STAGE_GAP_CYCLES edges after RST_OUT[NUM_STAGES-1] falls.
//   RUN:       READY=1; prescalers run.
//  Lock loss in RELEASE or RUN (!lock_ok sampled): next edge RST_OUT=all 1, READY=0, LOCK_LOST=1,
//   prescalers cleared, state=WAIT_LOCK. Full sequence repeats on relock.
//  Prescalers: us_cnt 0..TICK_US_DIV-1, ms_cnt 0..TICK_MS_DIV-1, held at 0 unless RUN. First TICK_US
//   TICK_US_DIV edges after READY rises. Counters wrap to 0 on their terminal count.
//  CLR_LOCK_LOST: clears LOCK_LOST next edge; if a loss event occurs the same edge, set wins.
//  Counter widths: $clog2 of each maximum (+1 where value range needs it); no overflow possible.
//  RST_OUT bits release monotonically; never deassert out of order, never glitch (all registered).
// TESTING (LOCK_STABLE_CYCLES=8, NUM_STAGES=3, STAGE_GAP_CYCLES=4, TICK_US_DIV=5, TICK_MS_DIV=3)
//  1 Reset, LOCK_IN=1 from edge 1 -> RST_OUT[0]=0 at edge 11, [1] at 15, [2] at 19, READY at 23,
//    TICK_US at 28/33/38, TICK_MS at 38 only.
//  2 LOCK_BYPASS=1, LOCK_IN=0 from edge 1 -> RST_OUT[0] falls edge 9, [2] edge 17, READY edge 21.
//  3 LOCK_IN low 1 cycle during STABLE -> back to WAIT_LOCK, stable count restarts, LOCK_LOST stays 0.
//  4 LOCK_IN falls in RUN -> within 3 edges RST_OUT=3'b111, READY=0, LOCK_LOST=1, ticks stop;
//    relock repeats test-1 timing relative to the rising edge of LOCK_IN.
//  5 CLR_LOCK_LOST asserted on the same edge as a new loss -> LOCK_LOST stays 1; alone -> clears.
//  6 FAB_RESET pulsed after RST_OUT[0] falls (mid-RELEASE) -> next edge RST_OUT=3'b111, READY=0, LOCK_LOST=0.

Source files
------------

// File: rtl/fab_clk_reset_sequencer_if.sv
// ---------------------------------------------------------------------------
// fab_clk_reset_sequencer_if
// Groups the lock inputs and the sequenced reset / timebase outputs of
// fab_clk_reset_sequencer. FAB_CLK and FAB_RESET stay plain ports on the block.
//
// Signals
//   LOCK_IN        CCC lock, asynchronous to FAB_CLK
//   LOCK_BYPASS    static strap, 1 = treat the clock as locked
//   CLR_LOCK_LOST  1-cycle pulse that clears LOCK_LOST
//   RST_OUT        active-high stage resets, bit 0 released first
//   READY          all stages released and the clock is locked
//   LOCK_LOST      sticky flag: lock dropped after a stage had been released
//   TICK_US        1-cycle timebase pulse
//   TICK_MS        1-cycle pulse coincident with every TICK_MS_DIV-th TICK_US
//   state_dbg      current sequencer state (0 WAIT_LOCK, 1 STABLE, 2 RELEASE, 3 RUN)
//
// Modports
//   master  drives the lock inputs and observes the outputs (clock-control side)
//   slave   the sequencer itself
//
// There is no valid/ready handshake on this interface: every input is a level
// or a single-cycle pulse, and every output is a registered level or pulse.
// ---------------------------------------------------------------------------
interface fab_clk_reset_sequencer_if #(
    parameter int NUM_STAGES = 3
);
    logic                  LOCK_IN;
    logic                  LOCK_BYPASS;
    logic                  CLR_LOCK_LOST;
    logic [NUM_STAGES-1:0] RST_OUT;
    logic                  READY;
    logic                  LOCK_LOST;
    logic                  TICK_US;
    logic                  TICK_MS;
    logic [1:0]            state_dbg;

    modport master (
        output LOCK_IN, LOCK_BYPASS, CLR_LOCK_LOST,
        input  RST_OUT, READY, LOCK_LOST, TICK_US, TICK_MS, state_dbg
    );

    modport slave (
        input  LOCK_IN, LOCK_BYPASS, CLR_LOCK_LOST,
        output RST_OUT, READY, LOCK_LOST, TICK_US, TICK_MS, state_dbg
    );
endinterface

// File: rtl/fab_clk_reset_sequencer.sv
// ---------------------------------------------------------------------------
// fab_clk_reset_sequencer
// Watches the MSS_CCC lock and holds the servo/turret logic in reset until
// FAB_CLK has been locked for LOCK_STABLE_CYCLES cycles. It then releases the
// stage resets one at a time, STAGE_GAP_CYCLES apart, raises READY and runs
// the microsecond/millisecond timebase. Losing lock after any release puts
// every stage back in reset, sets the sticky LOCK_LOST flag and restarts the
// whole sequence.
//
// Ports
//   FAB_CLK    in  fabric clock (sole clock)
//   FAB_RESET  in  synchronous active-high reset
//   bus        fab_clk_reset_sequencer_if.slave (lock inputs, stage resets,
//              READY, LOCK_LOST, TICK_US, TICK_MS, state_dbg)
// ---------------------------------------------------------------------------
module fab_clk_reset_sequencer #(
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int NUM_STAGES         = 3,
    parameter int STAGE_GAP_CYCLES   = 16,
    parameter int TICK_US_DIV        = 100,
    parameter int TICK_MS_DIV        = 1000
) (
    input  logic                          FAB_CLK,
    input  logic                          FAB_RESET,
    fab_clk_reset_sequencer_if.slave      bus
);
    localparam int CNT_W = $clog2(LOCK_STABLE_CYCLES);
    localparam int GAP_W = $clog2(STAGE_GAP_CYCLES + 1);
    localparam int US_W  = $clog2(TICK_US_DIV + 1);
    localparam int MS_W  = $clog2(TICK_MS_DIV + 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic                  lock_sync1, lock_sync2;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [GAP_W-1:0]      gap_q, gap_d;
    logic [NUM_STAGES-1:0] rst_q, rst_d;
    logic                  ready_q, ready_d;
    logic                  lost_q, lost_d;
    logic                  loss_event;
    logic [US_W-1:0]       us_q, us_d;
    logic [MS_W-1:0]       ms_q, ms_d;
    logic                  tick_us_q, tick_us_d;
    logic                  tick_ms_q, tick_ms_d;
    logic                  lock_ok;

    // The bypass strap is static, so it skips the synchroniser.
    assign lock_ok = lock_sync2 | bus.LOCK_BYPASS;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        gap_d      = gap_q;
        rst_d      = rst_q;
        ready_d    = ready_q;
        loss_event = 1'b0;
        us_d       = '0;
        ms_d       = '0;
        tick_us_d  = 1'b0;
        tick_ms_d  = 1'b0;

        case (state_q)
            WAIT_LOCK: begin
                if (lock_ok) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end
            end

            STABLE: begin
                if (!lock_ok) begin
                    // Nothing has been released yet, so this is not a loss event.
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                    gap_d   = '0;
                    rst_d   = rst_q << 1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            RELEASE: begin
                if (!lock_ok) begin
                    loss_event = 1'b1;
                end else if (gap_q == GAP_W'(STAGE_GAP_CYCLES - 1)) begin
                    gap_d = '0;
                    // Shifting a zero in from bit 0 releases stages strictly in
                    // order; once the top bit is clear every stage is out of reset.
                    if (rst_q[NUM_STAGES-1]) begin
                        rst_d = rst_q << 1;
                    end else begin
                        ready_d = 1'b1;
                        state_d = RUN;
                    end
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end

            RUN: begin
                if (!lock_ok) begin
                    loss_event = 1'b1;
                end else begin
                    us_d = us_q + US_W'(1);
                    ms_d = ms_q;
                    if (us_q == US_W'(TICK_US_DIV - 1)) begin
                        us_d      = '0;
                        tick_us_d = 1'b1;
                        if (ms_q == MS_W'(TICK_MS_DIV - 1)) begin
                            ms_d      = '0;
                            tick_ms_d = 1'b1;
                        end else begin
                            ms_d = ms_q + MS_W'(1);
                        end
                    end
                end
            end

            default: state_d = WAIT_LOCK;
        endcase

        if (loss_event) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
            gap_d   = '0;
            rst_d   = '1;
            ready_d = 1'b0;
        end

        // A loss on the same edge as a clear request leaves the flag set.
        if (loss_event)              lost_d = 1'b1;
        else if (bus.CLR_LOCK_LOST)  lost_d = 1'b0;
        else                         lost_d = lost_q;
    end

    always_ff @(posedge FAB_CLK) begin
        if (FAB_RESET) begin
            state_q    <= WAIT_LOCK;
            lock_sync1 <= 1'b0;
            lock_sync2 <= 1'b0;
            cnt_q      <= '0;
            gap_q      <= '0;
            rst_q      <= '1;
            ready_q    <= 1'b0;
            lost_q     <= 1'b0;
            us_q       <= '0;
            ms_q       <= '0;
            tick_us_q  <= 1'b0;
            tick_ms_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_sync1 <= bus.LOCK_IN;
            lock_sync2 <= lock_sync1;
            cnt_q      <= cnt_d;
            gap_q      <= gap_d;
            rst_q      <= rst_d;
            ready_q    <= ready_d;
            lost_q     <= lost_d;
            us_q       <= us_d;
            ms_q       <= ms_d;
            tick_us_q  <= tick_us_d;
            tick_ms_q  <= tick_ms_d;
        end
    end

    assign bus.RST_OUT   = rst_q;
    assign bus.READY     = ready_q;
    assign bus.LOCK_LOST = lost_q;
    assign bus.TICK_US   = tick_us_q;
    assign bus.TICK_MS   = tick_ms_q;
    assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_fab_clk_reset_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fab_clk_reset_sequencer
// Directed bench for fab_clk_reset_sequencer with LOCK_STABLE_CYCLES=8,
// NUM_STAGES=3, STAGE_GAP_CYCLES=4, TICK_US_DIV=5, TICK_MS_DIV=3.
// Edges are numbered from the reset edge (edge 0). Expected outputs come from
// hand-derived edge numbers: with RST_OUT[0] falling at edge r, RST_OUT[1]
// falls at r+4, RST_OUT[2] at r+8, READY rises at r+12, TICK_US pulses at
// r+17, r+22, r+27 and TICK_MS at r+27.
// ---------------------------------------------------------------------------
module tb_fab_clk_reset_sequencer;
    logic FAB_CLK   = 1'b0;
    logic FAB_RESET = 1'b1;
    int   edge_n    = 0;
    int   checks    = 0;
    int   errors    = 0;
    int   r;

    fab_clk_reset_sequencer_if #(.NUM_STAGES(3)) bus ();

    fab_clk_reset_sequencer #(
        .LOCK_STABLE_CYCLES (8),
        .NUM_STAGES         (3),
        .STAGE_GAP_CYCLES   (4),
        .TICK_US_DIV        (5),
        .TICK_MS_DIV        (3)
    ) dut (
        .FAB_CLK   (FAB_CLK),
        .FAB_RESET (FAB_RESET),
        .bus       (bus)
    );

    // ---------------- clock ----------------
    always #5 FAB_CLK = ~FAB_CLK;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge FAB_CLK);
        edge_n = edge_n + 1;
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            errors = errors + 1;
            $display("FAIL %s edge=%0d got=%0h expected=%0h", tag, edge_n, obs, exp);
        end
    endtask

    // Packs {RST_OUT, READY, TICK_US, TICK_MS, LOCK_LOST}.
    function automatic logic [6:0] observed();
        return {bus.RST_OUT, bus.READY, bus.TICK_US, bus.TICK_MS, bus.LOCK_LOST};
    endfunction

    // Steps to edge 'last', checking every edge against the release timeline
    // anchored on RST_OUT[0] falling at edge rel0.
    task automatic run_timeline(input string tag, input int rel0, input int last, input logic exp_lost);
        logic [6:0] exp;
        while (edge_n < last) begin
            tick();
            exp[6]  = !(edge_n >= rel0 + 8);
            exp[5]  = !(edge_n >= rel0 + 4);
            exp[4]  = !(edge_n >= rel0);
            exp[3]  = (edge_n >= rel0 + 12);
            exp[2]  = (edge_n == rel0 + 17) || (edge_n == rel0 + 22) || (edge_n == rel0 + 27);
            exp[1]  = (edge_n == rel0 + 27);
            exp[0]  = exp_lost;
            check(tag, 32'(observed()), 32'(exp));
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.LOCK_IN       = 1'b0;
        bus.LOCK_BYPASS   = 1'b0;
        bus.CLR_LOCK_LOST = 1'b0;

        // Test 1: reset, then LOCK_IN high sampled from edge 1.
        tick();
        edge_n = 0;
        check("reset_state", 32'(observed()), 32'(7'b111_0_0_0_0));
        FAB_RESET   = 1'b0;
        bus.LOCK_IN = 1'b1;
        run_timeline("t1_seq", 11, 40, 1'b0);

        // Test 4: lock drops in RUN; loss visible on the third edge.
        bus.LOCK_IN = 1'b0;
        ticks(3);
        check("t4_loss", 32'(observed()), 32'(7'b111_0_0_0_1));
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t4_held", 32'(observed()), 32'(7'b111_0_0_0_1));
        end
        bus.LOCK_IN = 1'b1;
        r = edge_n + 1 + 10;
        run_timeline("t4_relock", r, r + 28, 1'b1);

        // Test 6: reset pulsed mid-RELEASE while LOCK_LOST is set.
        bus.LOCK_IN = 1'b0;
        ticks(3);
        check("t6_loss", 32'(observed()), 32'(7'b111_0_0_0_1));
        ticks(3);
        bus.LOCK_IN = 1'b1;
        r = edge_n + 1 + 10;
        run_timeline("t6_release", r, r + 1, 1'b1);
        FAB_RESET = 1'b1;
        tick();
        check("t6_reset", 32'(observed()), 32'(7'b111_0_0_0_0));

        // Test 2: bypass strap with LOCK_IN low; reset edge is the new edge 0.
        edge_n          = 0;
        FAB_RESET       = 1'b0;
        bus.LOCK_IN     = 1'b0;
        bus.LOCK_BYPASS = 1'b1;
        run_timeline("t2_bypass", 9, 9 + 28, 1'b0);

        // Hand over from bypass to a real lock without a loss.
        bus.LOCK_IN = 1'b1;
        ticks(2);
        bus.LOCK_BYPASS = 1'b0;
        tick();
        check("t5_handover_ready", 32'(bus.READY), 32'd1);

        // Test 5: clear on the same edge as a loss leaves the flag set.
        bus.LOCK_IN = 1'b0;
        ticks(2);
        check("t5_pre_lost", 32'(bus.LOCK_LOST), 32'd0);
        bus.CLR_LOCK_LOST = 1'b1;
        tick();
        bus.CLR_LOCK_LOST = 1'b0;
        check("t5_set_wins", 32'(observed()), 32'(7'b111_0_0_0_1));
        tick();
        check("t5_sticky", 32'(bus.LOCK_LOST), 32'd1);
        bus.CLR_LOCK_LOST = 1'b1;
        tick();
        bus.CLR_LOCK_LOST = 1'b0;
        check("t5_clear", 32'(bus.LOCK_LOST), 32'd0);

        // Test 3: one-cycle lock glitch during STABLE restarts the count.
        bus.LOCK_IN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t3_pre", 32'(observed()), 32'(7'b111_0_0_0_0));
        end
        bus.LOCK_IN = 1'b0;
        tick();
        bus.LOCK_IN = 1'b1;
        r = edge_n + 1 + 10;
        run_timeline("t3_restart", r, r + 13, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
